// File: rtl/dmgplus_pkg.sv
// dmgplus_pkg: shared LCD geometry, VRAM word types and fill-engine enums.
package dmgplus_pkg;
    localparam int LCD_W = 160;
    localparam int LCD_H = 144;
    typedef logic [15:0] vram_addr_t;
    typedef logic [1:0]  vram_pix_t;
    typedef enum logic [1:0] {FILL_WHITE, FILL_BLACK, FILL_CHECK, FILL_BARS} fill_mode_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} fill_st_t;
    typedef struct packed {
        vram_addr_t addr;
        vram_pix_t  pix;
    } cap_word_t;
endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: capture word FIFO with fall-through head.
// When empty, the head shows the incoming word so a same-cycle push+pop bypasses storage.
module vram_wr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_12m,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  dmgplus_pkg::cap_word_t     wdata,
    output dmgplus_pkg::cap_word_t     head,
    output logic [$clog2(DEPTH):0]     count
);
    import dmgplus_pkg::*;
    localparam int AW = $clog2(DEPTH);
    cap_word_t     mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          empty, wr, rd;
    assign empty = count_q == '0;
    assign wr    = push && !(pop && empty);
    assign rd    = pop && !empty;
    assign head  = empty ? wdata : mem_q[rptr_q];
    assign count = count_q;
    always_ff @(posedge clk_12m or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wr ? wptr_q + 1'b1 : wptr_q;
            rptr_q  <= rd ? rptr_q + 1'b1 : rptr_q;
            count_q <= (wr && !rd) ? count_q + 1'b1 : (rd && !wr) ? count_q - 1'b1 : count_q;
        end
    end
    always_ff @(posedge clk_12m) begin
        if (wr) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/vram_wr_sched.sv
// vram_wr_sched: VRAM write-port arbiter between capture FIFO and frame fill engine.
// Define VRAM_WR_SCHED_PATTERN_EN to enable checkerboard/bars fill patterns.
module vram_wr_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int LCD_W      = dmgplus_pkg::LCD_W,
    parameter int LCD_H      = dmgplus_pkg::LCD_H,
    parameter int STARVE_LIM = 8
) (
    input  logic        clk_12m,
    input  logic        rstn,
    input  logic        cap_valid,
    input  logic [15:0] cap_addr,
    input  logic [1:0]  cap_data,
    output logic        cap_ready,
    input  logic        fill_start,
    input  logic [1:0]  fill_mode,
    output logic        fill_busy,
    output logic        fill_done,
    output logic [7:0]  ovf_cnt,
    output logic        vram_we,
    output logic [15:0] vram_addr,
    output logic [1:0]  vram_data
);
    import dmgplus_pkg::*;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]  X_LAST   = 8'(LCD_W - 1);
    localparam logic [7:0]  Y_LAST   = 8'(LCD_H - 1);
    fill_st_t      state_q, state_d;
    fill_mode_t    mode_q, mode_d;
    logic [7:0]    x_q, x_d, y_q, y_d, ovf_q, ovf_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          we_q;
    vram_addr_t    addr_q, addr_d;
    vram_pix_t     data_q, data_d, fill_pix;
    logic [AW:0]   count;
    cap_word_t     head, cap_word;
    logic          full, cap_avail, fill_req, grant_cap, grant_fill, push;
    assign cap_word   = {cap_addr, cap_data};
    assign full       = count == FULL_CNT;
    assign cap_ready  = !full;
    assign cap_avail  = count != '0 || cap_valid;
    assign fill_req   = state_q == ST_RUN;
    assign grant_cap  = cap_avail && (!fill_req || starve_q < SW'(STARVE_LIM));
    assign grant_fill = fill_req && !grant_cap;
    assign push       = cap_valid && (!full || grant_cap);
    assign ovf_cnt    = ovf_q;
    assign vram_we    = we_q;
    assign vram_addr  = addr_q;
    assign vram_data  = data_q;
    vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_12m (clk_12m),
        .rstn    (rstn),
        .push    (push),
        .pop     (grant_cap),
        .wdata   (cap_word),
        .head    (head),
        .count   (count)
    );
    always_comb begin
        starve_d = grant_fill ? '0 : (grant_cap && fill_req) ? starve_q + 1'b1 : starve_q;
        ovf_d    = (cap_valid && !push && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
        addr_d   = grant_cap ? head.addr : {y_q, x_q};
        data_d   = grant_cap ? head.pix : fill_pix;
    end
    always_ff @(posedge clk_12m or negedge rstn) begin
        if (!rstn) begin
            starve_q <= '0;
            ovf_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            starve_q <= starve_d;
            ovf_q    <= ovf_d;
            we_q     <= grant_cap || grant_fill;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end
    always_ff @(posedge clk_12m or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            mode_q  <= FILL_WHITE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: if (fill_start) begin
                state_d = ST_RUN;
                mode_d  = fill_mode_t'(fill_mode);
                x_d     = '0;
                y_d     = '0;
            end
            ST_RUN: if (grant_fill) begin
                x_d = x_q == X_LAST ? '0 : x_q + 8'd1;
                y_d = x_q == X_LAST ? y_q + 8'd1 : y_q;
                if (x_q == X_LAST && y_q == Y_LAST) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_comb begin
        fill_busy = state_q == ST_RUN;
        fill_done = state_q == ST_DONE;
`ifdef VRAM_WR_SCHED_PATTERN_EN
        fill_pix  = mode_q == FILL_BLACK ? 2'b11 :
                    mode_q == FILL_CHECK ? x_q[4:3] ^ y_q[4:3] :
                    mode_q == FILL_BARS  ? y_q[5:4] : 2'b00;
`else
        fill_pix  = mode_q == FILL_BLACK ? 2'b11 : 2'b00;
`endif
    end
endmodule

// File: tb/tb_vram_wr_sched.sv
// tb_vram_wr_sched: randomized scoreboard bench for vram_wr_sched.
module tb_vram_wr_sched;
    logic        clk_12m = 0, rstn = 0, cap_valid = 0, fill_start = 0;
    logic [15:0] cap_addr = 0;
    logic [1:0]  cap_data = 0, fill_mode = 0;
    logic        cap_ready, fill_busy, fill_done, vram_we;
    logic [7:0]  ovf_cnt;
    logic [15:0] vram_addr;
    logic [1:0]  vram_data;

    always #5 clk_12m = ~clk_12m;

    vram_wr_sched dut (
        .clk_12m(clk_12m), .rstn(rstn), .cap_valid(cap_valid), .cap_addr(cap_addr),
        .cap_data(cap_data), .cap_ready(cap_ready), .fill_start(fill_start),
        .fill_mode(fill_mode), .fill_busy(fill_busy), .fill_done(fill_done),
        .ovf_cnt(ovf_cnt), .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data)
    );

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [1:0]  data;
    } exp_t;

    exp_t        exp_q[$];
    logic [17:0] cq[$];
    int          ph = 0, idx = 0, starve = 0, ovf = 0, ndone = 0, npass = 0, ntot = 0;
    logic [1:0]  mode_m = 0;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        ntot++;
        if (a === e) npass++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endfunction

    function automatic logic [1:0] pix(logic [1:0] m, int x, int y);
        logic [7:0] xb, yb;
        xb = x[7:0];
        yb = y[7:0];
        if (m == 2'd1) return 2'b11;
`ifdef VRAM_WR_SCHED_PATTERN_EN
        if (m == 2'd2) return xb[4:3] ^ yb[4:3];
        if (m == 2'd3) return yb[5:4];
`endif
        return 2'b00;
    endfunction

    // Reference: capture queue with priority, fill walks a linear pixel index.
    task automatic model_step();
        exp_t        e;
        int          n;
        bit          avail, freq, gcap, gfill, full;
        logic [17:0] hd;
        n     = cq.size();
        full  = n == 4;
        avail = n > 0 || cap_valid;
        freq  = ph == 1;
        gcap  = avail && (!freq || starve < 8);
        gfill = freq && !gcap;
        e.we  = gcap || gfill;
        e.addr = 0;
        e.data = 0;
        if (gcap) begin
            hd = n > 0 ? cq[0] : {cap_addr, cap_data};
            e.addr = hd[17:2];
            e.data = hd[1:0];
            if (freq) starve++;
        end
        if (gfill) begin
            e.addr = {8'(idx / 160), 8'(idx % 160)};
            e.data = pix(mode_m, idx % 160, idx / 160);
            idx++;
            starve = 0;
        end
        if (cap_valid) begin
            if (!full || gcap) cq.push_back({cap_addr, cap_data});
            else if (ovf < 255) ovf++;
        end
        if (gcap) void'(cq.pop_front());
        if (ph == 2) ph = 0;
        else if (ph == 0 && fill_start) begin
            ph = 1;
            idx = 0;
            mode_m = fill_mode;
        end else if (ph == 1 && idx == 23040) ph = 2;
        exp_q.push_back(e);
    endtask

    task automatic check_status();
        chk("fill_busy", 32'(fill_busy), 32'(ph == 1));
        chk("fill_done", 32'(fill_done), 32'(ph == 2));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(ovf));
        chk("cap_ready", 32'(cap_ready), 32'(cq.size() != 4));
        if (fill_done) ndone++;
    endtask

    task automatic drive(input bit v, input logic [15:0] a, input logic [1:0] d,
                         input bit s, input logic [1:0] m);
        @(negedge clk_12m);
        check_status();
        cap_valid  = v;
        cap_addr   = a;
        cap_data   = d;
        fill_start = s;
        fill_mode  = m;
        model_step();
    endtask

    task automatic reset_checks();
        chk("rst_we", 32'(vram_we), 0);
        chk("rst_addr", 32'(vram_addr), 0);
        chk("rst_data", 32'(vram_data), 0);
        chk("rst_busy", 32'(fill_busy), 0);
        chk("rst_done", 32'(fill_done), 0);
        chk("rst_ovf", 32'(ovf_cnt), 0);
        chk("rst_ready", 32'(cap_ready), 1);
    endtask

    task automatic do_reset();
        @(negedge clk_12m);
        rstn = 0;
        cap_valid = 0;
        fill_start = 0;
        #1;
        reset_checks();
        ph = 0; idx = 0; starve = 0; ovf = 0;
        cq.delete();
        exp_q.delete();
        @(negedge clk_12m);
        rstn = 1;
    endtask

    always @(posedge clk_12m) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("vram_we", 32'(vram_we), 32'(e.we));
            if (e.we) begin
                chk("vram_addr", 32'(vram_addr), 32'(e.addr));
                chk("vram_data", 32'(vram_data), 32'(e.data));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk_12m);
        reset_checks();
        rstn = 1;
        drive(1, 16'h1234, 2'b10, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 2'b01);
        for (int i = 0; i < 23100 && ph != 0; i++) drive(0, 0, 0, 0, 0);
        chk("fill1_finished", 32'(ph), 0);
        repeat (3) drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 2'b10);
        for (int i = 0; i < 3000; i++)
            drive(1, 16'($urandom), 2'($urandom), ($urandom % 64) == 0, 2'($urandom));
        drive(0, 0, 0, 0, 0);
        chk("ovf_saturated", 32'(ovf_cnt), 255);
        for (int i = 0; i < 40000 && ph != 0; i++)
            drive(($urandom % 10) == 0, 16'($urandom), 2'($urandom), 0, 0);
        chk("fill2_finished", 32'(ph), 0);
        repeat (3) drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 2'b00);
        repeat (50 * 160 + 3) drive(0, 0, 0, 0, 0);
        do_reset();
        drive(0, 0, 0, 1, 2'b01);
        repeat (200) drive(0, 0, 0, 0, 0);
        @(negedge clk_12m);
        check_status();
        chk("done_pulses", 32'(ndone), 2);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
